// File: rtl/aerout_axis_tx.sv
// aerout_axis_tx
//   Return path from the ODIN core to the host. Output spike events arrive on
//   the AEROUT 4-phase handshake, are stamped with a prescaled 16-bit
//   timestamp, buffered in a small FIFO and sent out one at a time as 4-byte
//   AXI-Stream frames:
//     B0 = {4'b0011, ovf, 3'b000}, B1 = addr, B2 = ts[15:8], B3 = ts[7:0] (tlast)
//
// Ports
//   clk, rst_n      system clock, asynchronous active-low reset
//   AEROUT_ADDR     spiking neuron address (stable while REQ is high)
//   AEROUT_REQ      AER request, asynchronous to clk
//   AEROUT_ACK      AER acknowledge (registered)
//   m_axis_*        AXI-Stream byte master (tdata/tvalid/tready/tlast)
//   CFG_TX_ENABLE   allows new frames to start; frames in flight always finish
//   TS_CLEAR        synchronous clear of prescaler and timestamp
//   DROP_CNT        saturating count of events dropped on a full FIFO
//   FIFO_LEVEL      current FIFO occupancy
module aerout_axis_tx #(
  parameter int FIFO_DEPTH  = 16,
  parameter int TS_PRESCALE = 100,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  AEROUT_ADDR,
  input  logic                        AEROUT_REQ,
  output logic                        AEROUT_ACK,
  output logic [7:0]                  m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast,
  input  logic                        CFG_TX_ENABLE,
  input  logic                        TS_CLEAR,
  output logic [15:0]                 DROP_CNT,
  output logic [$clog2(FIFO_DEPTH):0] FIFO_LEVEL
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = (TS_PRESCALE > 1) ? $clog2(TS_PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TS_PRESCALE - 1);
  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

  // ---------------------------------------------------------------------------
  // Timestamp: prescaler 0..TS_PRESCALE-1, ts ticks on prescaler wrap.
  // TS_CLEAR wins over a coincident tick.
  // ---------------------------------------------------------------------------
  logic [PW-1:0] presc_reg;
  logic [15:0]   ts_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_reg <= '0;
      ts_reg    <= '0;
    end else if (TS_CLEAR) begin
      presc_reg <= '0;
      ts_reg    <= '0;
    end else if (presc_reg == PRESC_MAX) begin
      presc_reg <= '0;
      ts_reg    <= ts_reg + 16'd1;
    end else begin
      presc_reg <= presc_reg + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // REQ synchroniser
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] req_sync_reg;
  logic                   req_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_sync_reg <= '0;
    end else begin
      req_sync_reg <= {req_sync_reg[SYNC_STAGES-2:0], AEROUT_REQ};
    end
  end

  assign req_s = req_sync_reg[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // FIFO storage and status (declared early, used by both FSMs)
  // ---------------------------------------------------------------------------
  logic [24:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic [24:0]   rd_data_reg;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [24:0]   push_data;

  assign full  = (count_reg == DEPTH_CNT);
  assign empty = (count_reg == '0);

  // ---------------------------------------------------------------------------
  // Capture FSM
  // ---------------------------------------------------------------------------
  typedef enum logic {C_IDLE, C_ACK} cap_state_t;

  cap_state_t  cap_state_reg, cap_state_next;
  logic        ack_reg, ack_next;
  logic        ovf_reg, ovf_next;
  logic [15:0] drop_reg, drop_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_state_reg <= C_IDLE;
      ack_reg       <= 1'b0;
      ovf_reg       <= 1'b0;
      drop_reg      <= '0;
    end else begin
      cap_state_reg <= cap_state_next;
      ack_reg       <= ack_next;
      ovf_reg       <= ovf_next;
      drop_reg      <= drop_next;
    end
  end

  always_comb begin
    cap_state_next = cap_state_reg;
    ack_next       = ack_reg;
    ovf_next       = ovf_reg;
    drop_next      = drop_reg;
    push           = 1'b0;
    case (cap_state_reg)
      C_IDLE: begin
        if (req_s) begin
          // ODIN is never stalled: the event is either queued or dropped,
          // and acknowledged either way.
          ack_next       = 1'b1;
          cap_state_next = C_ACK;
          if (!full) begin
            push     = 1'b1;
            ovf_next = 1'b0;
          end else begin
            ovf_next = 1'b1;
            if (drop_reg != 16'hFFFF) begin
              drop_next = drop_reg + 16'd1;
            end
          end
        end
      end
      C_ACK: begin
        if (!req_s) begin
          ack_next       = 1'b0;
          cap_state_next = C_IDLE;
        end
      end
      default: begin
        ack_next       = 1'b0;
        cap_state_next = C_IDLE;
      end
    endcase
  end

  assign push_data = {ovf_reg, AEROUT_ADDR, ts_reg};

  // ---------------------------------------------------------------------------
  // FIFO: array write, registered read doubling as the frame register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      rd_data_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg  <= rd_ptr_reg + 1'b1;
        rd_data_reg <= mem[rd_ptr_reg];
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // TX FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {T_IDLE, T_B0, T_B1, T_B2, T_B3} tx_state_t;

  tx_state_t tx_state_reg, tx_state_next;
  logic      can_start;

  assign can_start = !empty && CFG_TX_ENABLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_reg <= T_IDLE;
    end else begin
      tx_state_reg <= tx_state_next;
    end
  end

  always_comb begin
    tx_state_next = tx_state_reg;
    pop           = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tdata  = 8'h00;
    case (tx_state_reg)
      T_IDLE: begin
        if (can_start) begin
          pop           = 1'b1;
          tx_state_next = T_B0;
        end
      end
      T_B0: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = {4'b0011, rd_data_reg[24], 3'b000};
        if (m_axis_tready) tx_state_next = T_B1;
      end
      T_B1: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = rd_data_reg[23:16];
        if (m_axis_tready) tx_state_next = T_B2;
      end
      T_B2: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = rd_data_reg[15:8];
        if (m_axis_tready) tx_state_next = T_B3;
      end
      T_B3: begin
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = 1'b1;
        m_axis_tdata  = rd_data_reg[7:0];
        if (m_axis_tready) begin
          // Back-to-back frames: reload the frame register on the last beat.
          if (can_start) begin
            pop           = 1'b1;
            tx_state_next = T_B0;
          end else begin
            tx_state_next = T_IDLE;
          end
        end
      end
      default: begin
        tx_state_next = T_IDLE;
      end
    endcase
  end

  assign AEROUT_ACK = ack_reg;
  assign DROP_CNT   = drop_reg;
  assign FIFO_LEVEL = count_reg;

endmodule

// File: tb/tb_aerout_axis_tx.sv
module tb_aerout_axis_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] AEROUT_ADDR;
  logic       AEROUT_REQ;
  logic       AEROUT_ACK;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic       m_axis_tlast;
  logic       CFG_TX_ENABLE;
  logic       TS_CLEAR;
  logic [15:0] DROP_CNT;
  logic [4:0] FIFO_LEVEL;

  int total = 0;
  int bad   = 0;

  logic [8:0] rxq[$];

  always #5 clk = ~clk;

  aerout_axis_tx #(
    .FIFO_DEPTH (16),
    .TS_PRESCALE(4),
    .SYNC_STAGES(2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .AEROUT_ADDR  (AEROUT_ADDR),
    .AEROUT_REQ   (AEROUT_REQ),
    .AEROUT_ACK   (AEROUT_ACK),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .CFG_TX_ENABLE(CFG_TX_ENABLE),
    .TS_CLEAR     (TS_CLEAR),
    .DROP_CNT     (DROP_CNT),
    .FIFO_LEVEL   (FIFO_LEVEL)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ts_clear();
    TS_CLEAR = 1'b1;
    step();
    TS_CLEAR = 1'b0;
  endtask

  task automatic aer_event(input logic [7:0] a, output int rise_lat, output int fall_lat);
    AEROUT_ADDR = a;
    AEROUT_REQ  = 1'b1;
    rise_lat = 0;
    while (!AEROUT_ACK && rise_lat < 20) begin
      step();
      rise_lat++;
    end
    AEROUT_REQ = 1'b0;
    fall_lat = 0;
    while (AEROUT_ACK && fall_lat < 20) begin
      step();
      fall_lat++;
    end
  endtask

  task automatic wait_rx(input int n, input int max_cyc);
    int c;
    c = 0;
    while (rxq.size() < n && c < max_cyc) begin
      step();
      c++;
    end
    check("rx_count", rxq.size(), n);
  endtask

  // Stream monitor: records beats and checks hold-while-stalled and
  // no tvalid drop inside a frame.
  initial begin
    logic       prev_stall;
    logic [7:0] prev_data;
    logic       prev_last;
    int         idx;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    idx        = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
        idx        = 0;
      end else begin
        if (prev_stall) begin
          check("stall_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tdata},
                {1'b1, prev_last, prev_data});
        end
        if (idx != 0) begin
          check("no_mid_drop", m_axis_tvalid, 1);
        end
        if (m_axis_tvalid && m_axis_tready) begin
          rxq.push_back({m_axis_tlast, m_axis_tdata});
          idx = m_axis_tlast ? 0 : idx + 1;
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_data  = m_axis_tdata;
        prev_last  = m_axis_tlast;
      end
    end
  end

  initial begin
    int rl, fl, acked, bubbles, c;
    logic seen;
    logic [15:0] pat;
    logic [8:0]  exp_bp [12];

    rst_n         = 1'b0;
    AEROUT_ADDR   = 8'h00;
    AEROUT_REQ    = 1'b0;
    m_axis_tready = 1'b0;
    CFG_TX_ENABLE = 1'b0;
    TS_CLEAR      = 1'b0;

    // Reset values
    repeat (3) step();
    rst_n = 1'b1;
    step();
    step();
    check("rst_ack", AEROUT_ACK, 0);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_drop", DROP_CNT, 0);
    check("rst_level", FIFO_LEVEL, 0);
    $display("reset values checked");

    // Single event: 42 cycles after clear -> ts = 10
    rxq.delete();
    CFG_TX_ENABLE = 1'b1;
    m_axis_tready = 1'b1;
    ts_clear();
    repeat (40) step();
    aer_event(8'hA5, rl, fl);
    check("ack_rise_lat", rl, 3);
    check("ack_fall_lat", fl, 3);
    wait_rx(4, 50);
    check("single_b0", rxq[0], 9'h030);
    check("single_b1", rxq[1], 9'h0A5);
    check("single_b2", rxq[2], 9'h000);
    check("single_b3", rxq[3], 9'h10A);
    $display("single event: %h %h %h %h", rxq[0], rxq[1], rxq[2], rxq[3]);

    // Backpressure: three queued events, ts = 0, 2, 3
    CFG_TX_ENABLE = 1'b0;
    m_axis_tready = 1'b0;
    rxq.delete();
    ts_clear();
    aer_event(8'h01, rl, fl);
    aer_event(8'h02, rl, fl);
    aer_event(8'h03, rl, fl);
    check("bp_level", FIFO_LEVEL, 3);
    exp_bp = '{9'h030, 9'h001, 9'h000, 9'h100,
               9'h030, 9'h002, 9'h000, 9'h102,
               9'h030, 9'h003, 9'h000, 9'h103};
    pat     = 16'b1001_0110_1001_1011;
    bubbles = 0;
    seen    = 1'b0;
    c       = 0;
    CFG_TX_ENABLE = 1'b1;
    while (rxq.size() < 12 && c < 200) begin
      m_axis_tready = pat[c % 16];
      if (seen && !m_axis_tvalid) bubbles++;
      if (m_axis_tvalid) seen = 1'b1;
      step();
      c++;
    end
    m_axis_tready = 1'b1;
    check("bp_bubbles", bubbles, 0);
    check("bp_count", rxq.size(), 12);
    for (int i = 0; i < 12; i++) begin
      check($sformatf("bp_byte%0d", i), rxq[i], exp_bp[i]);
    end
    $display("backpressure: %0d beats in %0d cycles", rxq.size(), c);

    // Enable dropped mid-frame
    CFG_TX_ENABLE = 1'b0;
    rxq.delete();
    aer_event(8'h11, rl, fl);
    aer_event(8'h22, rl, fl);
    check("en_level2", FIFO_LEVEL, 2);
    CFG_TX_ENABLE = 1'b1;
    step();
    check("en_b0", {m_axis_tvalid, m_axis_tdata}, 9'h130);
    step();
    check("en_b1", {m_axis_tvalid, m_axis_tdata}, 9'h111);
    CFG_TX_ENABLE = 1'b0;
    repeat (20) step();
    check("en_one_frame", rxq.size(), 4);
    check("en_idle_tvalid", m_axis_tvalid, 0);
    check("en_level1", FIFO_LEVEL, 1);
    check("en_f1_addr", rxq[1], 9'h011);
    check("en_f1_last", rxq[3][8], 1);
    CFG_TX_ENABLE = 1'b1;
    wait_rx(8, 50);
    check("en_f2_b0", rxq[4], 9'h030);
    check("en_f2_addr", rxq[5], 9'h022);
    check("en_level0", FIFO_LEVEL, 0);
    $display("enable mid-frame: %0d beats", rxq.size());

    // Overflow: 19 events into a 16-deep FIFO with TX disabled
    CFG_TX_ENABLE = 1'b0;
    rxq.delete();
    acked = 0;
    for (int i = 0; i < 19; i++) begin
      aer_event(8'(i), rl, fl);
      if (rl < 20 && fl < 20) acked++;
    end
    check("ovf_acked", acked, 19);
    check("ovf_level", FIFO_LEVEL, 16);
    check("ovf_drop", DROP_CNT, 3);
    CFG_TX_ENABLE = 1'b1;
    wait_rx(64, 200);
    for (int f = 0; f < 16; f++) begin
      check($sformatf("ovf_f%0d_b0", f), rxq[4*f], 9'h030);
      check($sformatf("ovf_f%0d_addr", f), rxq[4*f+1], {1'b0, 8'(f)});
      check($sformatf("ovf_f%0d_last", f), rxq[4*f+3][8], 1);
    end
    check("ovf_drain", FIFO_LEVEL, 0);
    rxq.delete();
    aer_event(8'h77, rl, fl);
    wait_rx(4, 50);
    check("ovf_flag_b0", rxq[0], 9'h038);
    check("ovf_flag_addr", rxq[1], 9'h077);
    check("ovf_drop_hold", DROP_CNT, 3);
    $display("overflow: drop=%0d flag byte=%h", DROP_CNT, rxq[0]);

    // Timestamp wrap 0xFFFF -> 0x0000
    rxq.delete();
    force dut.ts_reg    = 16'hFFFF;
    force dut.presc_reg = 2'd0;
    step();
    release dut.ts_reg;
    release dut.presc_reg;
    repeat (3) step();
    aer_event(8'h5A, rl, fl);
    wait_rx(4, 50);
    check("wrap_b0", rxq[0], 9'h030);
    check("wrap_addr", rxq[1], 9'h05A);
    check("wrap_ts_hi", rxq[2], 9'h000);
    check("wrap_ts_lo", rxq[3], 9'h100);
    $display("ts wrap: %h %h", rxq[2], rxq[3]);

    // TS_CLEAR coincident with a tick
    rxq.delete();
    ts_clear();
    repeat (3) step();
    TS_CLEAR = 1'b1;
    step();
    TS_CLEAR = 1'b0;
    aer_event(8'hC1, rl, fl);
    wait_rx(4, 50);
    check("clr_addr", rxq[1], 9'h0C1);
    check("clr_ts_hi", rxq[2], 9'h000);
    check("clr_ts_lo", rxq[3], 9'h100);
    $display("ts clear on tick: %h %h", rxq[2], rxq[3]);

    // Reset in the middle of a frame
    rxq.delete();
    m_axis_tready = 1'b0;
    aer_event(8'hC3, rl, fl);
    aer_event(8'hC4, rl, fl);
    check("mrst_level", FIFO_LEVEL, 1);
    check("mrst_b0", {m_axis_tvalid, m_axis_tdata}, 9'h130);
    m_axis_tready = 1'b1;
    step();
    check("mrst_b1", {m_axis_tvalid, m_axis_tdata}, 9'h1C3);
    m_axis_tready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mrst_tvalid", m_axis_tvalid, 0);
    check("mrst_tlast", m_axis_tlast, 0);
    check("mrst_tdata", m_axis_tdata, 0);
    check("mrst_drop", DROP_CNT, 0);
    check("mrst_level_now", FIFO_LEVEL, 0);
    step();
    step();
    m_axis_tready = 1'b1;
    rst_n = 1'b1;
    repeat (4) step();
    check("mrst_level_after", FIFO_LEVEL, 0);
    check("mrst_tvalid_after", m_axis_tvalid, 0);
    check("mrst_no_resend", rxq.size(), 1);
    $display("reset mid-frame: beats=%0d level=%0d", rxq.size(), FIFO_LEVEL);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aerout_axis_tx.md
Name: aerout_axis_tx

Overview:
Return path from the ODIN core to the host. Captures output spike events from the AEROUT 4-phase handshake and timestamps each one. Events are buffered in a small FIFO and each is serialised as a 4-byte AXI-Stream frame toward the host link. It is the mirror of the inbound AXI-Stream command decoder.

Parameters:
FIFO_DEPTH, 16, number of buffered events; power of 2, >= 2
TS_PRESCALE, 100, clk cycles per timestamp tick; >= 1
SYNC_STAGES, 2, flip-flop stages on AEROUT_REQ; >= 2

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
AEROUT_ADDR  input  8  spiking neuron address from ODIN
AEROUT_REQ  input  1  AER request from ODIN (asynchronous to clk)
AEROUT_ACK  output  1  AER acknowledge to ODIN
m_axis_tdata  output  8  stream byte
m_axis_tvalid  output  1  stream valid
m_axis_tready  input  1  stream ready
m_axis_tlast  output  1  high on last byte of a frame
CFG_TX_ENABLE  input  1  allows new frames to start
TS_CLEAR  input  1  synchronous clear of the timestamp
DROP_CNT  output  16  events dropped because the FIFO was full; saturating
FIFO_LEVEL  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst_n low, asynchronous):
  - Outputs: AEROUT_ACK, m_axis_tvalid, m_axis_tlast, m_axis_tdata, DROP_CNT and FIFO_LEVEL are all 0.
  - Internal state: FIFO empty, timestamp and prescaler 0, overflow flag 0, both FSMs idle.
  - Reset mid-frame abandons the frame; no partial resend after release.
- Timestamp:
  - Prescaler counts 0..TS_PRESCALE-1. On wrap, the 16-bit ts increments; 0xFFFF wraps to 0x0000.
  - TS_CLEAR zeroes prescaler and ts in the next cycle and has priority over increment.
- Capture FSM, states C_IDLE and C_ACK. req_s is AEROUT_REQ after SYNC_STAGES flops.
  - C_IDLE with req_s=1: sample AEROUT_ADDR and the current ts. ADDR is stable under the bundled-data rule.
    - If the FIFO is not full: push {ovf, addr, ts} and clear ovf.
    - If the FIFO is full: drop the event, set ovf, DROP_CNT+1 (saturates at 0xFFFF).
    - In both cases assert AEROUT_ACK (registered) and go to C_ACK. ODIN is never stalled.
  - C_ACK: hold ACK=1 until req_s=0, then ACK<=0 and return to C_IDLE.
  - Latency: REQ rise to ACK rise is SYNC_STAGES+1 cycles.
- FIFO:
  - 25-bit entries, registered read data, FIFO_LEVEL updates the cycle after push/pop.
  - Full is evaluated before a same-cycle pop: a push while full is dropped even if a pop happens that cycle.
  - A push and pop in the same cycle on a non-full FIFO leaves the level unchanged.
- TX FSM, states T_IDLE, T_B0, T_B1, T_B2, T_B3.
  - T_IDLE: if FIFO not empty and CFG_TX_ENABLE=1, pop into the frame register. Go to T_B0 with tvalid=1 from the next cycle.
  - Frame bytes:
    - B0 = {4'b0011, ovf, 3'b000}
    - B1 = addr
    - B2 = ts[15:8]
    - B3 = ts[7:0], with tlast=1
  - Advance one byte only on tvalid&&tready. tdata, tvalid and tlast are held stable while tready=0. tvalid never drops mid-frame.
  - On the B3 handshake: if FIFO not empty and enabled, pop and go to T_B0 with no bubble; otherwise go to T_IDLE with tvalid=0.
  - CFG_TX_ENABLE=0 only blocks starting a frame; a frame in progress always completes.
- Throughput: with tready tied high, one frame per 4 cycles.

Test Plan:
- Reset values: release rst_n, no stimulus -> ACK=0, tvalid=0, DROP_CNT=0, FIFO_LEVEL=0. Assert rst_n during B1 -> tvalid=0 immediately, FIFO_LEVEL=0 after release.
- Single event: TS_PRESCALE=4, TS_CLEAR, wait 40 cycles, 4-phase event ADDR=0xA5, tready=1 -> ACK rises SYNC_STAGES+1 cycles after REQ. Frame is 0x30, 0xA5, 0x00, 0x0A with tlast only on the last byte. ACK falls after REQ falls.
- Backpressure: tready toggles 1-0-0-1 pseudo-randomly during three queued events (0x01, 0x02, 0x03) -> 12 bytes in order, payload unchanged while stalled, three tlast pulses, no bubble between frames while tready=1.
- Overflow: CFG_TX_ENABLE=0, send FIFO_DEPTH+3 events (addr = index) -> FIFO_LEVEL=16, DROP_CNT=3, every event ACKed. Then enable -> 16 frames, addr 0..15, ovf=0 in all. Next event 0x77 gives B0=0x38.
- Timestamp wrap and clear: force ts to 0xFFFF, let one tick elapse, send event -> ts bytes 0x00, 0x00. TS_CLEAR in the same cycle as a tick -> ts=0.
- Enable mid-frame: drop CFG_TX_ENABLE during B1 with 2 events queued -> current frame completes, no further tvalid until re-enabled.
